// File: rtl/pb_led_pkg.sv
`default_nettype none
// ==== pb_led_pkg : shared mode encoding and default timing constants (rev 1.0) ====
package pb_led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_MIRROR = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_TICK_CYCLES     = 25000000;

endpackage
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ==== pb_debounce : one button channel - 2-FF sync, stability counter, debounced level, rise pulse ====
// ==== Build option PB_ACTIVE_LOW_EN inverts the raw pin ahead of the synchroniser. (rev 1.0) ====
module pb_debounce
  import pb_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic debounced,
  output logic pressed
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pb_pol;
  logic             sync1;
  logic             sync2;
  logic             db_prev;
  logic [CNT_W-1:0] cnt;

`ifdef PB_ACTIVE_LOW_EN
  assign pb_pol = ~pb_in;
`else
  assign pb_pol = pb_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      debounced <= 1'b0;
      db_prev   <= 1'b0;
      pressed   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1   <= pb_pol;
      sync2   <= sync1;
      db_prev <= debounced;
      // Pulse lands the cycle after the debounced level rises.
      pressed <= debounced & ~db_prev;
      if (sync2 == debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        debounced <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pb_led_tester.sv
`default_nettype none
// ==== pb_led_tester : debounced push buttons driving a four-mode LED pattern machine ====
// ==== Build option PB_ACTIVE_LOW_EN selects pulled-up (active-low) buttons. (rev 1.0) ====
module pb_led_tester
  import pb_led_pkg::*;
#(
  parameter int NUM_PB          = 2,
  parameter int NUM_LED         = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_CYCLES     = DEF_TICK_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PB-1:0]  pb_in,
  output logic [NUM_LED-1:0] led_out,
  output logic [MODE_W-1:0]  mode,
  output logic [NUM_PB-1:0]  pb_pressed
);

  localparam int                 TICK_W    = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [NUM_LED-1:0] WALK_INIT = NUM_LED'(1);

  logic [NUM_PB-1:0]  debounced;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic               adv;
  logic               step;
  mode_t              state;
  mode_t              state_nxt;
  logic [NUM_LED-1:0] pattern;
  logic [NUM_LED-1:0] pattern_nxt;
  logic [NUM_LED-1:0] led_nxt;
  logic [NUM_LED-1:0] mirror;
  logic               walk_rev;
  logic               walk_rev_nxt;
  logic               blink_hold;
  logic               blink_hold_nxt;

  for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb_debounce (
      .clk       (clk),
      .rst       (rst),
      .pb_in     (pb_in[i]),
      .debounced (debounced[i]),
      .pressed   (pb_pressed[i])
    );
  end

  assign tick = (tick_cnt == TICK_LAST);
  assign adv  = pb_pressed[0];
  // Mode advance takes priority; a coincident step press is dropped.
  assign step = pb_pressed[1] & ~adv;
  assign mode = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_comb begin
    mirror = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      if (i < NUM_PB) begin
        mirror[i] = debounced[i];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    pattern_nxt    = pattern;
    walk_rev_nxt   = walk_rev;
    blink_hold_nxt = blink_hold;
    if (adv) begin
      walk_rev_nxt   = 1'b0;
      blink_hold_nxt = 1'b0;
      case (state)
        MODE_MIRROR: begin
          state_nxt   = MODE_COUNT;
          pattern_nxt = '0;
        end
        MODE_COUNT: begin
          state_nxt   = MODE_WALK;
          pattern_nxt = WALK_INIT;
        end
        MODE_WALK: begin
          state_nxt   = MODE_BLINK;
          pattern_nxt = '0;
        end
        default: begin
          state_nxt   = MODE_MIRROR;
          pattern_nxt = '0;
        end
      endcase
    end else begin
      case (state)
        MODE_COUNT: begin
          if (step) pattern_nxt = pattern + 1'b1;
        end
        MODE_WALK: begin
          if (step) walk_rev_nxt = ~walk_rev;
          if (tick) begin
            pattern_nxt = walk_rev_nxt ? {pattern[0], pattern[NUM_LED-1:1]}
                                       : {pattern[NUM_LED-2:0], pattern[NUM_LED-1]};
          end
        end
        MODE_BLINK: begin
          if (step) blink_hold_nxt = ~blink_hold;
          if (tick && !blink_hold_nxt) pattern_nxt = ~pattern;
        end
        default: ;
      endcase
    end
    led_nxt = (state_nxt == MODE_MIRROR) ? mirror : pattern_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MODE_MIRROR;
      pattern    <= '0;
      walk_rev   <= 1'b0;
      blink_hold <= 1'b0;
      led_out    <= '0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      walk_rev   <= walk_rev_nxt;
      blink_hold <= blink_hold_nxt;
      led_out    <= led_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_led_tester.sv
`default_nettype none
// ==== tb_pb_led_tester : directed + random stimulus against a behavioural model of pb_led_tester (rev 1.0) ====
module tb_pb_led_tester;

  localparam int D    = 4;
  localparam int T    = 8;
  localparam int NPB  = 2;
  localparam int NLED = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NPB-1:0]  btn = 2'b11;
  logic [NPB-1:0]  pb_in;
  logic [NLED-1:0] led_out;
  logic [1:0]      mode;
  logic [NPB-1:0]  pb_pressed;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PB_ACTIVE_LOW_EN
  assign pb_in = ~btn;
`else
  assign pb_in = btn;
`endif

  always #5 clk = ~clk;

  pb_led_tester #(
    .NUM_PB          (NPB),
    .NUM_LED         (NLED),
    .DEBOUNCE_CYCLES (D),
    .TICK_CYCLES     (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pb_in      (pb_in),
    .led_out    (led_out),
    .mode       (mode),
    .pb_pressed (pb_pressed)
  );

  // Behavioural model: buttons as run lengths, patterns as integers/positions.
  logic [1:0] m_s1, m_s2, m_db, m_rise;
  int         m_run [2];
  int         m_tc, m_mode, m_cnt, m_pos;
  bit         m_rev, m_lit, m_hold, m_tick, m_adv, m_stp;
  logic       m_sy;
  logic [2:0] exp_led  = '0;
  logic [1:0] exp_mode = '0;
  logic [1:0] exp_pr   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_tc = 0; m_mode = 0; m_cnt = 0; m_pos = 0;
      m_rev = 0; m_lit = 0; m_hold = 0;
      exp_led = '0; exp_mode = '0; exp_pr = '0;
    end else begin
      m_tick = (m_tc == T - 1);
      m_tc   = (m_tc + 1) % T;
      m_adv  = exp_pr[0];
      m_stp  = exp_pr[1] && !m_adv;
      if (m_adv) begin
        m_mode = (m_mode + 1) % 4;
        m_cnt = 0; m_pos = 0; m_rev = 0; m_lit = 0; m_hold = 0;
      end else begin
        case (m_mode)
          1: if (m_stp) m_cnt = (m_cnt + 1) % 8;
          2: begin
            if (m_stp) m_rev = !m_rev;
            if (m_tick) m_pos = m_rev ? (m_pos + 2) % 3 : (m_pos + 1) % 3;
          end
          3: begin
            if (m_stp) m_hold = !m_hold;
            if (m_tick && !m_hold) m_lit = !m_lit;
          end
          default: ;
        endcase
      end
      case (m_mode)
        0:       exp_led = {1'b0, m_db};
        1:       exp_led = 3'(m_cnt);
        2:       exp_led = 3'(1 << m_pos);
        default: exp_led = m_lit ? 3'b111 : 3'b000;
      endcase
      exp_mode = 2'(m_mode);
      for (int i = 0; i < 2; i++) begin
        m_sy    = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = btn[i];
        exp_pr[i] = m_rise[i];
        m_rise[i] = 1'b0;
        if (m_sy != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_db[i]   = m_sy;
            m_run[i]  = 0;
            m_rise[i] = m_sy;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("model_led", 8'(led_out), 8'(exp_led));
    chk("model_mode", 8'(mode), 8'(exp_mode));
    chk("model_pressed", 8'(pb_pressed), 8'(exp_pr));
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat ($urandom_range(6, 9)) step();
    btn[b] = 1'b0;
    repeat ($urandom_range(6, 9)) step();
  endtask

  task automatic wait_mode(input logic [1:0] m, input int lim);
    int k;
    k = 0;
    while (mode !== m && k < lim) begin
      step();
      k++;
    end
    chk("wait_mode", 8'(mode), 8'(m));
  endtask

  task automatic wait_led_change(input logic [2:0] prev, input int lim, output int waited);
    waited = 0;
    while (led_out === prev && waited < lim) begin
      step();
      waited++;
    end
    n_assert++;
    assert (led_out !== prev) else begin
      n_fail++;
      $error("FAIL led_change_timeout observed=%b expected=change_from_%b", led_out, prev);
    end
  endtask

  logic [2:0] v;
  int         w;

  initial begin
    // Reset held with both buttons pressed
    @(posedge clk);
    repeat (3) begin
      step();
      chk("rst_led", 8'(led_out), 8'h00);
      chk("rst_mode", 8'(mode), 8'h00);
      chk("rst_pressed", 8'(pb_pressed), 8'h00);
    end
    rst = 1'b0;
    btn = 2'b00;
    step();
    chk("post_rst_led", 8'(led_out), 8'h00);
    chk("post_rst_pressed", 8'(pb_pressed), 8'h00);

    // Short glitches never qualify
    btn[0] = 1'b1; repeat (3) step(); btn[0] = 1'b0;
    repeat (4) begin
      step();
      btn[0] = 1'b1; repeat ($urandom_range(1, 3)) step();
      btn[0] = 1'b0; repeat ($urandom_range(1, 4)) step();
    end
    repeat (10) step();
    chk("glitch_mode", 8'(mode), 8'h00);

    // Clean hold: pulse on cycle 7, mode advances on cycle 8
    btn[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("pb0_pulse", 8'(pb_pressed[0]), 8'(k == 7));
      chk("pb0_mode", 8'(mode), (k >= 8) ? 8'h01 : 8'h00);
    end
    btn[0] = 1'b0;
    repeat (8) step();

    // COUNT wraps through 7 back to 0
    for (int n = 0; n < 9; n++) begin
      press(1);
      chk("count_seq", 8'(led_out), 8'((n + 1) % 8));
    end
    chk("count_end", 8'(led_out), 8'h01);

    // WALK: entry one-hot, then rotate left every T cycles
    btn[0] = 1'b1;
    wait_mode(2'd2, 12);
    chk("walk_entry", 8'(led_out), 8'h01);
    btn[0] = 1'b0;
    v = led_out;
    wait_led_change(v, T + 1, w);
    chk("walk_1", 8'(led_out), 8'h02);
    v = led_out;
    wait_led_change(v, T + 1, w);
    chk("walk_2", 8'(led_out), 8'h04);
    chk("walk_period", 8'(w), 8'(T));
    v = led_out;
    wait_led_change(v, T + 1, w);
    chk("walk_3", 8'(led_out), 8'h01);
    chk("walk_period", 8'(w), 8'(T));
    press(1);
    v = led_out;
    wait_led_change(v, T + 1, w);
    chk("walk_reverse", 8'(led_out), 8'({v[0], v[2:1]}));

    // Simultaneous presses in COUNT at value 3
    press(0); press(0); press(0);
    repeat (3) press(1);
    chk("simul_pre_mode", 8'(mode), 8'h01);
    chk("simul_pre_led", 8'(led_out), 8'h03);
    btn = 2'b11;
    wait_mode(2'd2, 12);
    chk("simul_led", 8'(led_out), 8'h01);
    btn = 2'b00;
    repeat (10) step();

    // BLINK, pause, then reset with a debounce half done
    press(0);
    chk("blink_mode", 8'(mode), 8'h03);
    repeat (20) step();
    press(1);
    repeat (12) step();
    btn = 2'b11;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_led", 8'(led_out), 8'h00);
    chk("midrst_mode", 8'(mode), 8'h00);
    chk("midrst_pressed", 8'(pb_pressed), 8'h00);
    rst = 1'b0;
    btn = 2'b00;
    repeat (6) step();
    btn[1] = 1'b1; repeat (3) step(); btn[1] = 1'b0;
    repeat (12) begin
      step();
      chk("short_no_pulse", 8'(pb_pressed), 8'h00);
    end

    // Random button activity against the model
    repeat (60) begin
      btn = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 12)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
